// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem bus initiator and the benches that drive it.
package iomem_pkg;

    localparam int IOMEM_AW = 32;
    localparam int IOMEM_DW = 32;
    localparam int IOMEM_SW = 4;

    localparam logic [7:0] GPIO_BASE = 8'h03;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } iomem_state_t;

endpackage

// File: rtl/iomem_initiator.sv
// Runs one iomem transaction per accepted command and reports read data or a timeout
// error back on a valid/ready response channel.
module iomem_initiator
    import iomem_pkg::*;
#(
    parameter int                  TIMEOUT_CYCLES = 255,
    parameter logic [IOMEM_DW-1:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                clk_pll,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IOMEM_AW-1:0] cmd_addr,
    input  logic [IOMEM_DW-1:0] cmd_wdata,
    input  logic [IOMEM_SW-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IOMEM_DW-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic                iomem_valid,
    input  logic                iomem_ready,
    output logic [IOMEM_SW-1:0] iomem_wstrb,
    output logic [IOMEM_AW-1:0] iomem_addr,
    output logic [IOMEM_DW-1:0] iomem_wdata,
    input  logic [IOMEM_DW-1:0] iomem_rdata
);

    localparam int               CW         = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0]    CNT_MAX    = '1;
    localparam logic [CW-1:0]    CNT_LAST   = TIMEOUT_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    iomem_state_t  state, state_next;
    logic [CW-1:0] count;
    logic          accept, bus_done, bus_timeout, rsp_done;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk_pll) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Ready is checked before the timeout so a response on the last allowed cycle still completes.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        bus_done    = 1'b0;
        bus_timeout = 1'b0;
        rsp_done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                if (iomem_ready) begin
                    bus_done   = 1'b1;
                    state_next = RSP;
                end else if (TIMEOUT_EN && count == CNT_LAST) begin
                    bus_timeout = 1'b1;
                    state_next  = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            iomem_valid <= 1'b0;
            iomem_addr  <= '0;
            iomem_wdata <= '0;
            iomem_wstrb <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            count       <= '0;
        end else begin
            if (accept) begin
                iomem_valid <= 1'b1;
                iomem_addr  <= cmd_addr;
                iomem_wdata <= cmd_wdata;
                iomem_wstrb <= cmd_wstrb;
                count       <= '0;
            end
            if (bus_done) begin
                iomem_valid <= 1'b0;
                rsp_valid   <= 1'b1;
                rsp_rdata   <= iomem_rdata;
                rsp_err     <= 1'b0;
            end else if (bus_timeout) begin
                iomem_valid <= 1'b0;
                rsp_valid   <= 1'b1;
                rsp_rdata   <= ERR_RDATA;
                rsp_err     <= 1'b1;
            end else if (state == BUS && count != CNT_MAX) begin
                count <= count + CW'(1);
            end
            if (rsp_done) begin
                rsp_valid   <= 1'b0;
                iomem_wstrb <= '0;
            end
        end
    end

endmodule

// File: tb/tb_iomem_initiator.sv
// Bench for iomem_initiator: table vectors, hand-written corner sequences and
// randomized transactions checked against a latency-based transaction model.
module tb_iomem_initiator;
    import iomem_pkg::*;

    localparam int TO = 8;

    logic        clk_pll, resetn;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        iomem_valid, iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] rdata;
        int          rsp_delay;
        int          exp_cycles;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    iomem_initiator #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEADBEEF)) dut (
        .clk_pll(clk_pll), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
    );

    initial begin
        clk_pll = 1'b0;
        forever #5 clk_pll = ~clk_pll;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Responder latency L means ready arrives on valid cycle L; beyond the timeout it never arrives.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.lat < TO) begin
            r.exp_cycles = v.lat + 1;
            r.exp_rdata  = v.rdata;
            r.exp_err    = 1'b0;
        end else begin
            r.exp_cycles = TO;
            r.exp_rdata  = 32'hDEADBEEF;
            r.exp_err    = 1'b1;
        end
        return r;
    endfunction

    task automatic finishRsp(input logic [31:0] exp_rdata, input logic exp_err);
        rsp_ready = 1'b1;
        @(posedge clk_pll); @(negedge clk_pll);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        checkOutput("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
        checkOutput("wstrb_cleared", 32'(iomem_wstrb), 32'd0);
        checkOutput("rsp_rdata_kept", rsp_rdata, exp_rdata);
        checkOutput("rsp_err_kept", 32'(rsp_err), 32'(exp_err));
    endtask

    task automatic applyStimulus(input vec_t v, input bit finish_rsp);
        int  cyc, cycles;
        bit  bus_ok, rsp_ok;
        @(negedge clk_pll);
        checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_wstrb = v.wstrb;
        @(posedge clk_pll); @(negedge clk_pll);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);
        cyc = 0; cycles = 0; bus_ok = 1'b1;
        while (iomem_valid === 1'b1 && cyc < 300) begin
            cycles++;
            if (iomem_addr !== v.addr || iomem_wdata !== v.wdata ||
                iomem_wstrb !== v.wstrb || cmd_ready !== 1'b0 || rsp_valid !== 1'b0)
                bus_ok = 1'b0;
            iomem_ready = (cyc == v.lat);
            iomem_rdata = (cyc == v.lat) ? v.rdata : $urandom;
            @(posedge clk_pll); @(negedge clk_pll);
            iomem_ready = 1'b0;
            cyc++;
        end
        checkOutput("bus_bound", 32'(cyc < 300), 32'd1);
        checkOutput("valid_cycles", 32'(cycles), 32'(v.exp_cycles));
        checkOutput("bus_stable", 32'(bus_ok), 32'd1);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_rdata", rsp_rdata, v.exp_rdata);
        checkOutput("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        rsp_ok = 1'b1;
        for (int i = 0; i < v.rsp_delay; i++) begin
            @(posedge clk_pll); @(negedge clk_pll);
            if (rsp_valid !== 1'b1 || rsp_rdata !== v.exp_rdata || rsp_err !== v.exp_err ||
                cmd_ready !== 1'b0 || iomem_valid !== 1'b0)
                rsp_ok = 1'b0;
        end
        checkOutput("rsp_hold", 32'(rsp_ok), 32'd1);
        if (finish_rsp) finishRsp(v.exp_rdata, v.exp_err);
    endtask

    vec_t table_v[6];
    vec_t v;
    bit   ok;

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0; iomem_ready = 1'b0; iomem_rdata = '0;

        table_v[0] = '{{GPIO_BASE, 24'h0}, 32'h0000_00A5, 4'b0001, 1,  32'h0BAD_F00D, 0, 2, 32'h0BAD_F00D, 1'b0};
        table_v[1] = '{{GPIO_BASE, 24'h0}, 32'h0,         4'b0000, 5,  32'h1234_5678, 1, 6, 32'h1234_5678, 1'b0};
        table_v[2] = '{{GPIO_BASE, 24'h4}, 32'h0,         4'b0000, 99, 32'h0,         0, 8, 32'hDEAD_BEEF, 1'b1};
        table_v[3] = '{{GPIO_BASE, 24'h8}, 32'h0,         4'b0000, 7,  32'hCAFE_BABE, 2, 8, 32'hCAFE_BABE, 1'b0};
        table_v[4] = '{32'h0000_1000,      32'hFFFF_0000, 4'b1111, 0,  32'h55AA_55AA, 0, 1, 32'h55AA_55AA, 1'b0};
        table_v[5] = '{32'h0200_0004,      32'h0000_0001, 4'b0011, 6,  32'h7777_0001, 3, 7, 32'h7777_0001, 1'b0};

        repeat (2) @(posedge clk_pll);
        @(negedge clk_pll);
        checkOutput("reset_iomem_valid", 32'(iomem_valid), 32'd0);
        checkOutput("reset_iomem_addr", iomem_addr, 32'd0);
        checkOutput("reset_iomem_wdata", iomem_wdata, 32'd0);
        checkOutput("reset_iomem_wstrb", 32'(iomem_wstrb), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        resetn = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) applyStimulus(table_v[i], 1'b1);

        $display("[TB] timeout then late ready pulse");
        v = table_v[2];
        v.rsp_delay = 3;
        applyStimulus(v, 1'b0);
        iomem_ready = 1'b1;
        iomem_rdata = 32'h1111_1111;
        @(posedge clk_pll); @(negedge clk_pll);
        iomem_ready = 1'b0;
        checkOutput("late_ready_rdata", rsp_rdata, 32'hDEAD_BEEF);
        checkOutput("late_ready_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("late_ready_iomem_valid", 32'(iomem_valid), 32'd0);
        finishRsp(32'hDEAD_BEEF, 1'b1);

        $display("[TB] response backpressure with pending command");
        v = model('{{GPIO_BASE, 24'h20}, 32'h0, 4'b0000, 2, 32'hABCD_0123, 0, 0, 32'h0, 1'b0});
        applyStimulus(v, 1'b0);
        cmd_valid = 1'b1; cmd_addr = {GPIO_BASE, 24'h10}; cmd_wdata = 32'h0000_005A; cmd_wstrb = 4'b0001;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_pll); @(negedge clk_pll);
            if (cmd_ready !== 1'b0 || iomem_valid !== 1'b0 || rsp_valid !== 1'b1 ||
                rsp_rdata !== 32'hABCD_0123 || rsp_err !== 1'b0)
                ok = 1'b0;
        end
        checkOutput("backpressure_hold", 32'(ok), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk_pll); @(negedge clk_pll);
        rsp_ready = 1'b0;
        checkOutput("no_accept_in_hs_cycle", 32'(iomem_valid), 32'd0);
        checkOutput("bp_rsp_valid_low", 32'(rsp_valid), 32'd0);
        checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk_pll); @(negedge clk_pll);
        cmd_valid = 1'b0;
        checkOutput("bp_accept_valid", 32'(iomem_valid), 32'd1);
        checkOutput("bp_accept_addr", iomem_addr, {GPIO_BASE, 24'h10});
        iomem_ready = 1'b1; iomem_rdata = 32'h0000_0042;
        @(posedge clk_pll); @(negedge clk_pll);
        iomem_ready = 1'b0;
        checkOutput("bp_second_rdata", rsp_rdata, 32'h0000_0042);
        finishRsp(32'h0000_0042, 1'b0);

        $display("[TB] reset during bus phase");
        cmd_valid = 1'b1; cmd_addr = {GPIO_BASE, 24'h30}; cmd_wdata = 32'h1; cmd_wstrb = 4'b1111;
        @(posedge clk_pll); @(negedge clk_pll);
        cmd_valid = 1'b0;
        @(posedge clk_pll); @(negedge clk_pll);
        checkOutput("pre_reset_valid", 32'(iomem_valid), 32'd1);
        resetn = 1'b0;
        @(posedge clk_pll); @(negedge clk_pll);
        resetn = 1'b1;
        checkOutput("mid_reset_iomem_valid", 32'(iomem_valid), 32'd0);
        checkOutput("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_reset_addr", iomem_addr, 32'd0);
        checkOutput("mid_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        iomem_ready = 1'b1; iomem_rdata = 32'h9999_9999;
        @(posedge clk_pll); @(negedge clk_pll);
        iomem_ready = 1'b0;
        checkOutput("post_reset_ready_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("post_reset_ready_cmd", 32'(cmd_ready), 32'd1);
        checkOutput("post_reset_ready_rdata", rsp_rdata, 32'd0);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            v.addr      = $urandom;
            v.wdata     = $urandom;
            v.wstrb     = 4'($urandom);
            v.lat       = $urandom_range(0, 11);
            v.rdata     = $urandom;
            v.rsp_delay = $urandom_range(0, 3);
            applyStimulus(model(v), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iomem_initiator.md
Name: iomem_initiator

Overview:
- Bus-master counterpart to the iomem peripherals on the picosoc iomem port (e.g. the 0x03xx_xxxx GPIO responder).
- Accepts single read/write commands over a valid/ready command channel and runs one iomem transaction per command.
- Returns read data and an error flag over a valid/ready response channel.
- Guards against a missing responder with a cycle timeout.
- Used by debug/test bridges to script peripherals without the CPU.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles iomem_valid is held awaiting iomem_ready; 0 disables the timeout.
- ERR_RDATA, 32'hDEADBEEF, rsp_rdata value returned on timeout.

Ports:
- clk_pll  input  1  system clock; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_addr  input  32  transaction byte address.
- cmd_wdata  input  32  write data.
- cmd_wstrb  input  4  byte write strobes; 4'b0000 = read.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  32  captured iomem_rdata or ERR_RDATA.
- rsp_err  output  1  1 = transaction timed out.
- iomem_valid  output  1  transaction request.
- iomem_ready  input  1  responder completion pulse.
- iomem_wstrb  output  4  byte strobes to responder.
- iomem_addr  output  32  address to responder.
- iomem_wdata  output  32  write data to responder.
- iomem_rdata  input  32  responder read data, valid with iomem_ready.

Behaviour:
- Reset (resetn=0 at an edge): state IDLE, counter 0. Outputs: iomem_valid=0, iomem_addr/wdata=0, iomem_wstrb=0, rsp_valid=0, rsp_err=0, rsp_rdata=0. cmd_ready=1 from the first cycle after reset.
- Reset mid-transaction aborts it. No response is produced. A later iomem_ready is ignored.
- FSM states IDLE, BUS, RSP. cmd_ready = (state==IDLE), combinational from state only.
- IDLE:
  - On cmd_valid&&cmd_ready, register addr/wdata/wstrb onto the iomem_* outputs, set iomem_valid=1, clear the counter, go to BUS.
  - Latency: iomem_valid rises on the edge that accepts the command.
- BUS:
  - iomem_valid and iomem_addr/wdata/wstrb are held stable.
  - Counter increments each cycle iomem_ready=0.
  - On iomem_ready=1: capture iomem_rdata into rsp_rdata (also on writes), rsp_err=0, iomem_valid=0 at that edge, rsp_valid=1, go to RSP. iomem_valid never stays high past the ready cycle, so a one-cycle ready pulse completes exactly one transaction.
  - Timeout: if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 and iomem_ready=0, then iomem_valid=0, rsp_rdata=ERR_RDATA, rsp_err=1, rsp_valid=1, go to RSP. iomem_valid is therefore high for exactly TIMEOUT_CYCLES cycles.
  - iomem_ready on the final timeout cycle: ready wins, normal completion.
- RSP:
  - rsp_valid, rsp_rdata and rsp_err are held until rsp_valid&&rsp_ready.
  - At that edge: rsp_valid=0, go to IDLE. rsp_rdata/rsp_err keep their last value.
  - No new command is accepted in the same cycle; minimum command-to-command spacing is 3 cycles.
- iomem_ready while in IDLE or RSP (late or spurious) is ignored; no state change.
- iomem_wstrb is cleared to 0 when returning to IDLE. iomem_addr/wdata keep their last value.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1; the counter saturates rather than wraps.

Decomposition:
- Shared package iomem_pkg:
  - state enum (IDLE/BUS/RSP).
  - IOMEM_AW=32, IOMEM_DW=32, IOMEM_SW=4.
  - GPIO base 8'h03 for benches.
- No sub-module needed. The timeout counter stays inline.

Test Plan:
- Write: cmd addr=0x0300_0000, wdata=0x0000_00A5, wstrb=4'b0001; responder asserts ready 1 cycle after valid -> iomem_valid high for exactly 2 cycles with stable addr/wdata/wstrb; rsp_valid=1, rsp_err=0.
- Read: cmd addr=0x0300_0000, wstrb=0; responder returns 0x1234_5678 with ready after 5 cycles -> rsp_rdata=0x1234_5678, rsp_err=0; iomem_valid falls at the ready edge.
- Timeout: TIMEOUT_CYCLES=8, no responder -> iomem_valid high exactly 8 cycles, rsp_rdata=0xDEADBEEF, rsp_err=1; a ready pulse 3 cycles later is ignored.
- Boundary: ready asserted on the 8th (last) valid cycle with TIMEOUT_CYCLES=8 -> normal completion, rsp_err=0, captured rdata.
- Backpressure: rsp_ready held 0 for 10 cycles -> rsp outputs stable, cmd_ready=0 throughout; a cmd_valid offered meanwhile is accepted only after the response handshake.
- Reset mid-BUS: resetn=0 for 1 cycle while iomem_valid=1 -> iomem_valid=0, rsp_valid=0 next cycle, cmd_ready=1 after release; no response emitted.
